gate_resp_compactor: RTL
========================

# gate_resp_compactor

Downstream response-compaction stage for the 19-input/10-output gate-model netlists in the gate library. Accepts one 10-bit output vector per handshake from the device under test, folds each into a multiple-input signature register (MISR), and counts accepted patterns. After a programmed number of patterns it compares the signature against an expected value and reports pass/fail. This turns a long combinational test run into one signature check in the lab simulator.

## Interface
- IN_W, 10: width of the response vector (gate-model output count).
- SIG_W, 16: signature width. Must be ≥ IN_W.
- POLY, 16'h1021: MISR feedback polynomial (taps, x^SIG_W implied).
- SEED, 16'hFFFF: signature value loaded on start and on reset.
- CNT_W, 16: pattern counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse. Begins a run; ignored unless in IDLE or DONE.
- num_patterns  in  CNT_W  pattern count for the run, sampled on accepted start.
- expected_sig  in  SIG_W  golden signature, sampled on accepted start.
- resp_valid  in  1  resp_data is valid.
- resp_data  in  IN_W  response vector from the gate model.
- resp_ready  out  1  high only in RUN.
- busy  out  1  high in RUN and CHECK.
- done  out  1  high in DONE; stays high until the next accepted start or reset.
- pass  out  1  result of the signature compare. Valid while done=1; 0 otherwise.
- signature  out  SIG_W  current MISR value.
- pattern_count  out  CNT_W  number of vectors accepted in the current run.
- toggle_mask  out  IN_W  accumulated per-bit toggle coverage (see Configuration).

## Operation
- The FSM has four states: IDLE, RUN, CHECK, DONE.
- IDLE/DONE + start: latch num_patterns and expected_sig, set signature=SEED and pattern_count=0, clear done/pass, go to RUN.
- RUN, transfer (resp_valid && resp_ready): signature ← {signature[SIG_W-2:0],1'b0} ^ (signature[SIG_W-1] ? POLY : 0) ^ zero-extended resp_data; pattern_count += 1.
- RUN → CHECK when pattern_count == latched num_patterns. Test this at the start of each RUN cycle, before any transfer.
  - num_patterns=0 gives RUN→CHECK after one cycle with zero transfers, because resp_ready is suppressed when the count is already met.
  - resp_ready = (state==RUN) && (pattern_count != num_latched). An extra vector is therefore never accepted.
- CHECK: pass_r ← (signature == expected_latched); go to DONE.
- DONE: hold signature, pattern_count and pass. A new start restarts the run.
- start in RUN or CHECK is ignored.
- resp_valid with no transfer (IDLE, CHECK, DONE) is ignored; resp_data is don't-care.
- pattern_count does not wrap: the largest run is 2^CNT_W−1 patterns.

## Timing
- Reset (rst_n=0 at a clock edge) gives state=IDLE, signature=SEED, pattern_count=0, resp_ready=0, busy=0, done=0, pass=0, toggle_mask=0.
- Reset mid-run aborts with no done pulse.
- Start accepted at edge k: resp_ready=1 from cycle k+1.
- The last transfer at edge n moves the FSM to CHECK at edge n+1 and to DONE at edge n+2; done and pass are visible after edge n+2.
- End-of-run latency from the last transfer to done is 2 cycles.
- signature is visible one cycle after each transfer edge.
- Throughput is one vector per cycle with resp_valid held high.

## Configuration
- GATE_RESP_TOGGLE_EN defined:
  - toggle_mask |= resp_data ^ prev_data on every transfer after the first of a run.
  - prev_data is registered on each transfer.
  - toggle_mask is cleared on start.
- Undefined: toggle_mask is tied to 0 and no prev_data register exists. The port list is unchanged.

## Structure
- Package gate_resp_pkg holds the FSM state enum, and the default POLY and SEED constants.
- One sub-module, gate_resp_misr, contains the signature register and its next-state logic: load, enable, data in, signature out.
- The top level contains the FSM, counter, compare and toggle logic.

## Test plan
- num_patterns=1, resp_data=10'h000 → signature=16'hEFDF. With expected_sig=16'hEFDF: pass=1 and done=1, two cycles after the transfer.
- num_patterns=1, resp_data=10'h3FF, expected_sig=16'hEFDF → signature=16'hEC20, pass=0.
- num_patterns=0, expected_sig=16'hFFFF → no transfers, resp_ready stays 0, done with pass=1 and signature=16'hFFFF.
- num_patterns=3 with valid toggling 1,0,1,0,1:
  - exactly 3 transfers and pattern_count=3;
  - a 4th valid vector is not accepted;
  - start pulsed mid-run is ignored.
- rst_n=0 for one cycle while pattern_count=2 → all outputs reach their reset values; a new start then runs normally from SEED.
- With GATE_RESP_TOGGLE_EN, vectors 10'h001, 10'h003, 10'h001 → toggle_mask=10'h002. Without the macro, toggle_mask=0.

Source files
------------

// File: rtl/gate_resp_pkg.sv
// gate_resp_pkg: shared FSM state encoding and default MISR constants
// for the gate-model response compactor.
`default_nettype none

package gate_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] DEFAULT_POLY = 16'h1021;
  localparam logic [15:0] DEFAULT_SEED = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/gate_resp_misr.sv
// ============================================================================
// gate_resp_misr: multiple-input signature register, seed load and fold-in
// Revision: 1.0
// ============================================================================
`default_nettype none

module gate_resp_misr #(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021,
  parameter logic [SIG_W-1:0] SEED  = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [SIG_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q, sig_d;

  // Load has priority so a restart never folds in a stale vector.
  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = SEED;
    end else if (en) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sig_q <= SEED;
    else        sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

`default_nettype wire

// File: rtl/gate_resp_compactor.sv
// ============================================================================
// gate_resp_compactor: folds gate-model response vectors into a MISR, counts
// patterns and compares the final signature. Optional toggle coverage is
// enabled with the GATE_RESP_TOGGLE_EN macro.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gate_resp_compactor
  import gate_resp_pkg::*;
#(
  parameter int               IN_W  = 10,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = DEFAULT_POLY,
  parameter logic [SIG_W-1:0] SEED  = DEFAULT_SEED,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [SIG_W-1:0] expected_sig,
  input  logic             resp_valid,
  input  logic [IN_W-1:0]  resp_data,
  output logic             resp_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] pattern_count,
  output logic [IN_W-1:0]  toggle_mask
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [SIG_W-1:0] exp_q, exp_d;
  logic             pass_q, pass_d;

  logic start_ok;
  logic xfer;

  assign start_ok   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // Ready drops as soon as the count is met, so no extra vector slips in.
  assign resp_ready = (state_q == ST_RUN) && (cnt_q != num_q);
  assign xfer       = resp_valid && resp_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    exp_d   = exp_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          num_d   = num_patterns;
          exp_d   = expected_sig;
          cnt_d   = '0;
          pass_d  = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == num_q)  state_d = ST_CHECK;
        else if (xfer)       cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_CHECK: begin
        pass_d  = (signature == exp_q);
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      exp_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      exp_q   <= exp_d;
      pass_q  <= pass_d;
    end
  end

  gate_resp_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_ok),
    .en    (xfer),
    .din   (SIG_W'(resp_data)),
    .sig   (signature)
  );

  assign busy          = (state_q == ST_RUN) || (state_q == ST_CHECK);
  assign done          = (state_q == ST_DONE);
  assign pass          = pass_q;
  assign pattern_count = cnt_q;

`ifdef GATE_RESP_TOGGLE_EN
  logic [IN_W-1:0] prev_q, prev_d;
  logic [IN_W-1:0] tmask_q, tmask_d;
  logic            has_prev_q, has_prev_d;

  // The first vector of a run has no predecessor and contributes no toggles.
  always_comb begin
    prev_d     = prev_q;
    tmask_d    = tmask_q;
    has_prev_d = has_prev_q;
    if (start_ok) begin
      tmask_d    = '0;
      has_prev_d = 1'b0;
    end else if (xfer) begin
      if (has_prev_q) tmask_d = tmask_q | (resp_data ^ prev_q);
      prev_d     = resp_data;
      has_prev_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q     <= '0;
      tmask_q    <= '0;
      has_prev_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      tmask_q    <= tmask_d;
      has_prev_q <= has_prev_d;
    end
  end

  assign toggle_mask = tmask_q;
`else
  assign toggle_mask = '0;
`endif

endmodule

`default_nettype wire
